// File: rtl/hazard_pkg.sv
// Shared encodings and limits for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    START    = 2'd0,
    RUN      = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_t;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STALL_W  = 16;

  localparam logic [REG_W-1:0]   REG_ZERO      = 5'd0;
  localparam logic [STALL_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage read of a register still being loaded by the EX instruction.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic             mem_read,
  input  logic [REG_W-1:0] dst_addr,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = uses_rs && (rs == dst_addr);
  assign rt_hit   = uses_rt && (rt == dst_addr);
  // $0 is hardwired, so a load into it can never feed a consumer.
  assign load_use = mem_read && (dst_addr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: start-up flush, load-use
// bubbles, taken-branch squash and MDU freezes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned STARTUP_FLUSH_CYCLES = 2,
  parameter int unsigned MDU_LATENCY          = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_W-1:0]    Rs_ID,
  input  logic [REG_W-1:0]    Rt_ID,
  input  logic                UsesRs_ID,
  input  logic                UsesRt_ID,
  input  logic                MduStart_ID,
  input  logic                MemRead_IDEX,
  input  logic [REG_W-1:0]    RegWriteAddr_IDEX,
  input  logic                BranchTaken_EX,
  output logic                PC_Stall,
  output logic                IF_Stall,
  output logic                IF_Flush,
  output logic                ID_Stall,
  output logic                ID_Flush,
  output logic                MduBusy,
  output logic [STALL_W-1:0]  StallCycles
);

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(STARTUP_FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] MDU_CNT   = CNT_W'(MDU_LATENCY - 1);

  hz_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load_use;
  logic             in_start;

  load_use_detect u_load_use_detect (
    .mem_read (MemRead_IDEX),
    .dst_addr (RegWriteAddr_IDEX),
    .rs       (Rs_ID),
    .rt       (Rt_ID),
    .uses_rs  (UsesRs_ID),
    .uses_rt  (UsesRt_ID),
    .load_use (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= START;
      cnt         <= START_CNT;
      StallCycles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (PC_Stall && !in_start && (StallCycles != STALL_CNT_MAX))
        StallCycles <= StallCycles + STALL_W'(1);
    end
  end

  // Next-state and output decode; the unused encoding behaves as START.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_start = 1'b0;
    PC_Stall = 1'b0;
    IF_Stall = 1'b0;
    IF_Flush = 1'b0;
    ID_Stall = 1'b0;
    ID_Flush = 1'b0;
    MduBusy  = 1'b0;

    case (state)
      RUN: begin
        if (BranchTaken_EX) begin
          IF_Flush = 1'b1;
          ID_Flush = 1'b1;
        end else if (load_use) begin
          PC_Stall = 1'b1;
          IF_Stall = 1'b1;
          ID_Flush = 1'b1;
        end else if (MduStart_ID) begin
          state_nx = MDU_WAIT;
          cnt_nx   = MDU_CNT;
        end
      end

      MDU_WAIT: begin
        PC_Stall = 1'b1;
        IF_Stall = 1'b1;
        ID_Stall = 1'b1;
        MduBusy  = 1'b1;
        cnt_nx   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = RUN;
      end

      default: begin
        in_start = 1'b1;
        PC_Stall = 1'b1;
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
        cnt_nx   = cnt - CNT_W'(1);
        state_nx = (cnt == CNT_W'(1)) ? RUN : START;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs_ID, Rt_ID, RegWriteAddr_IDEX;
  logic        UsesRs_ID, UsesRt_ID, MduStart_ID, MemRead_IDEX, BranchTaken_EX;
  logic        PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, MduBusy;
  logic [15:0] StallCycles;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // {PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, MduBusy}
  localparam logic [15:0] P_IDLE  = 16'b000000;
  localparam logic [15:0] P_FLUSH = 16'b101010;
  localparam logic [15:0] P_LU    = 16'b110010;
  localparam logic [15:0] P_BR    = 16'b001010;
  localparam logic [15:0] P_MDU   = 16'b110101;

  hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .Rs_ID             (Rs_ID),
    .Rt_ID             (Rt_ID),
    .UsesRs_ID         (UsesRs_ID),
    .UsesRt_ID         (UsesRt_ID),
    .MduStart_ID       (MduStart_ID),
    .MemRead_IDEX      (MemRead_IDEX),
    .RegWriteAddr_IDEX (RegWriteAddr_IDEX),
    .BranchTaken_EX    (BranchTaken_EX),
    .PC_Stall          (PC_Stall),
    .IF_Stall          (IF_Stall),
    .IF_Flush          (IF_Flush),
    .ID_Stall          (ID_Stall),
    .ID_Flush          (ID_Flush),
    .MduBusy           (MduBusy),
    .StallCycles       (StallCycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return 16'({PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, MduBusy});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs_ID = '0; Rt_ID = '0; RegWriteAddr_IDEX = '0;
    UsesRs_ID = 0; UsesRt_ID = 0; MduStart_ID = 0; MemRead_IDEX = 0; BranchTaken_EX = 0;
  endtask

  task automatic set_lu(input logic [4:0] dst);
    MemRead_IDEX = 1; RegWriteAddr_IDEX = dst; Rs_ID = dst; UsesRs_ID = 1;
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    #2;
    chk("startup1", outs(), P_FLUSH);
    chk("startup1_sc", StallCycles, 16'd0);
    tick(); #2;
    chk("startup2", outs(), P_FLUSH);
    tick(); #2;
    chk("run_idle", outs(), P_IDLE);
    chk("run_sc", StallCycles, 16'd0);

    // load-use on rs
    set_lu(5'd8); #2;
    chk("lu_rs", outs(), P_LU);
    tick(); clr(); #2;
    chk("lu_rs_after", outs(), P_IDLE);
    chk("lu_rs_sc", StallCycles, 16'd1);

    // load into $0 never stalls
    set_lu(5'd0); #2;
    chk("lu_zero", outs(), P_IDLE);
    tick(); clr(); #2;
    chk("lu_zero_sc", StallCycles, 16'd1);

    // load-use on rt
    MemRead_IDEX = 1; RegWriteAddr_IDEX = 5'd9; Rt_ID = 5'd9; UsesRt_ID = 1; #2;
    chk("lu_rt", outs(), P_LU);
    tick(); clr(); #2;
    chk("lu_rt_sc", StallCycles, 16'd2);

    // matching field that is not read
    MemRead_IDEX = 1; RegWriteAddr_IDEX = 5'd8; Rs_ID = 5'd8; UsesRs_ID = 0; #2;
    chk("lu_unused", outs(), P_IDLE);
    tick(); clr();

    // branch beats load-use and MDU start
    set_lu(5'd8); BranchTaken_EX = 1; MduStart_ID = 1; #2;
    chk("br_vs_lu", outs(), P_BR);
    tick(); clr(); #2;
    chk("br_after", outs(), P_IDLE);
    chk("br_sc", StallCycles, 16'd2);

    // MDU freeze: issue cycle free, then 3 frozen cycles
    MduStart_ID = 1; #2;
    chk("mdu_issue", outs(), P_IDLE);
    tick(); clr(); #2;
    chk("mdu_w1", outs(), P_MDU);
    tick(); BranchTaken_EX = 1; #2;
    chk("mdu_w2_br", outs(), P_MDU);
    tick(); BranchTaken_EX = 0; #2;
    chk("mdu_w3", outs(), P_MDU);
    tick(); #2;
    chk("mdu_done", outs(), P_IDLE);
    chk("mdu_sc", StallCycles, 16'd5);

    // load-use masks MDU start
    set_lu(5'd3); MduStart_ID = 1; #2;
    chk("lu_vs_mdu", outs(), P_LU);
    tick(); clr(); #2;
    chk("lu_vs_mdu_after", outs(), P_IDLE);
    chk("lu_vs_mdu_sc", StallCycles, 16'd6);

    // reset during second MDU_WAIT cycle
    MduStart_ID = 1;
    tick(); clr(); #2;
    chk("rmdu_w1", outs(), P_MDU);
    tick(); rst = 1; #2;
    chk("rmdu_w2", outs(), P_MDU);
    tick(); rst = 0; #2;
    chk("rmdu_flush1", outs(), P_FLUSH);
    chk("rmdu_sc", StallCycles, 16'd0);
    tick(); #2;
    chk("rmdu_flush2", outs(), P_FLUSH);
    tick(); #2;
    chk("rmdu_run", outs(), P_IDLE);

    // saturation: a held load-use stalls every cycle
    set_lu(5'd4);
    repeat (65534) tick();
    #2;
    chk("sat_fffe", StallCycles, 16'hFFFE);
    tick(); #2;
    chk("sat_ffff", StallCycles, 16'hFFFF);
    repeat (5) tick();
    #2;
    chk("sat_hold", StallCycles, 16'hFFFF);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
